// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder: state encodings and default operand width.
package serial_adder_ctrl_pkg;

    localparam int unsigned DefWidth = 8;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_e;

endpackage

// File: rtl/fa_cell.sv
// Single-bit full adder, the one arithmetic cell time-shared by the serial adder.
module fa_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    always_comb begin
        s_o = a_i ^ b_i ^ c_i;
        c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
    end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands LSB-first through one fa_cell.
// Optional subtraction is enabled by defining SERIAL_ADD_SUB_EN.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             ready,
    output logic             busy,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             done
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;
    logic               fa_s, fa_c;
    logic               b_inv;
    logic               carry_init;

`ifdef SERIAL_ADD_SUB_EN
    // a - b computed as a + ~b + 1
    assign b_inv      = sub;
    assign carry_init = sub;
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign b_inv      = 1'b0;
    assign carry_init = 1'b0;
`endif

    fa_cell u_fa_cell (
        .a_i (a_sh_q[0]),
        .b_i (b_sh_q[0]),
        .c_i (carry_q),
        .s_o (fa_s),
        .c_o (fa_c)
    );

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b_inv ? ~b : b;
                    carry_d = carry_init;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                a_sh_d            = a_sh_q >> 1;
                b_sh_d            = b_sh_q >> 1;
                res_d             = res_q >> 1;
                res_d[WIDTH-1]    = fa_s;
                carry_d           = fa_c;
                cnt_d             = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    // carry_q here is the carry into the MSB
                    sum_d   = res_d;
                    cout_d  = fa_c;
                    ovf_d   = carry_q ^ fa_c;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign ready = (state_q == StIdle);
    assign busy  = (state_q == StRun);
    assign sum   = sum_q;
    assign cout  = cout_q;
    assign ovf   = ovf_q;
    assign done  = done_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl at WIDTH=8; covers SERIAL_ADD_SUB_EN when defined.
module tb_serial_adder_ctrl;

    localparam int unsigned W = 8;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } res_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         sub_in = 1'b0;
    logic         ready, busy, cout, ovf, done;
    logic [W-1:0] sum;

    int   n_cmp = 0;
    int   n_err = 0;
    res_t exp_q[$];
    res_t hold = '0;
    logic done_prev = 1'b0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a_in),
        .b     (b_in),
        .sub   (sub_in),
        .ready (ready),
        .busy  (busy),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        logic [W:0] t;
        res_t       r;
`ifdef SERIAL_ADD_SUB_EN
        if (s) begin
            t      = {1'b0, x} - {1'b0, y};
            r.sum  = t[W-1:0];
            r.cout = (x >= y);
            r.ovf  = (x[W-1] != y[W-1]) && (r.sum[W-1] != x[W-1]);
            return r;
        end
`endif
        t      = {1'b0, x} + {1'b0, y};
        r.sum  = t[W-1:0];
        r.cout = t[W] | (s & 1'b0);
        r.ovf  = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
        return r;
    endfunction

    // Output monitor: pops on every done pulse, checks outputs hold between pulses.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            hold = '0;
        end else begin
            if (done) begin
                if (exp_q.size() == 0) chk("spurious_done", 1, 0);
                else hold = exp_q.pop_front();
            end
            chk("done_twice", {31'd0, done & done_prev}, 0);
            chk("result", {23'd0, sum, cout, ovf}, {23'd0, hold});
        end
        done_prev = done;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        chk("ready_before_start", {31'd0, ready}, 1);
        a_in   = x;
        b_in   = y;
        sub_in = s;
        start  = 1'b1;
        exp_q.push_back(model(x, y, s));
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_accept", {31'd0, busy}, 1);
    endtask

    task automatic wait_done(input int expect_n);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!done && n < 40);
        chk("latency", n, expect_n);
        chk("ready_in_done", {31'd0, ready}, 1);
    endtask

    initial begin
        idle(3);
        chk("rst_ready", {31'd0, ready}, 1);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_outs", {23'd0, sum, cout, ovf}, 0);
        rst = 1'b0;
        idle(2);

        launch(8'h05, 8'h03, 1'b0);
        wait_done(W);
        idle(2);
        launch(8'hFF, 8'h01, 1'b0);
        wait_done(W);
        idle(1);
        launch(8'h7F, 8'h01, 1'b0);
        wait_done(W);
        launch(8'h80, 8'h80, 1'b0);  // back-to-back in the done cycle
        wait_done(W);
        idle(3);

        // start re-asserted with new operands during RUN must be ignored
        launch(8'h11, 8'h22, 1'b0);
        idle(2);
        a_in  = 8'h99;
        b_in  = 8'h99;
        start = 1'b1;
        idle(3);
        start = 1'b0;
        wait_done(W - 5);
        idle(12);

        // reset in the 4th RUN cycle discards the operation
        launch(8'h33, 8'h44, 1'b0);
        idle(3);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("midrst_ready", {31'd0, ready}, 1);
        chk("midrst_sum", {24'd0, sum}, 0);
        chk("midrst_done", {31'd0, done}, 0);
        idle(12);
        launch(8'h10, 8'h20, 1'b0);
        wait_done(W);
        idle(2);

        // reset wins over a simultaneous start
        rst   = 1'b1;
        start = 1'b1;
        a_in  = 8'h01;
        b_in  = 8'h01;
        idle(1);
        rst   = 1'b0;
        start = 1'b0;
        chk("rst_start_ready", {31'd0, ready}, 1);
        chk("rst_start_busy", {31'd0, busy}, 0);
        idle(12);

`ifdef SERIAL_ADD_SUB_EN
        launch(8'h05, 8'h07, 1'b1);
        wait_done(W);
        launch(8'h80, 8'h01, 1'b1);
        wait_done(W);
        idle(2);
`else
        launch(8'h05, 8'h07, 1'b1);  // sub ignored: addition
        wait_done(W);
        idle(2);
`endif

        for (int i = 0; i < 8; i++) begin
            launch(W'($urandom), W'($urandom), 1'($urandom));
            wait_done(W);
            if (i[0]) idle(1 + int'($urandom_range(0, 2)));
        end
        idle(3);
        chk("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
